// File: rtl/data_cache_pkg.sv
// Shared definitions for the data-cache blocks: flush sequencer states and qword geometry.
package data_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } flush_state_t;

    localparam int QWORD_BYTES = 16;
    localparam int QWORD_BITS  = 128;

endpackage

// File: rtl/data_cache_flush_ctrl.sv
// Writes back the dirty qwords of one cache block, one memory transaction per qword,
// then strobes the block so each written-back qword has its dirty bit cleared.
module data_cache_flush_ctrl
    import data_cache_pkg::*;
#(
    parameter int QWORD_COUNT    = 8,
    parameter int IDX_WIDTH      = $clog2(QWORD_COUNT),
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [QWORD_COUNT-1:0]    dirty_i,
    input  logic                      wr_conflict_i,
    output logic [IDX_WIDTH-1:0]      qword_addr_o,
    input  logic [QWORD_BITS-1:0]     qword_data_i,
    output logic [QWORD_COUNT-1:0]    flushing_n_o,
    output logic                      cleaned_n_o,
    output logic                      mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [QWORD_BITS-1:0]     mem_wdata_o,
    input  logic                      mem_ack_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [IDX_WIDTH:0]        wb_count_o
);

    localparam int                   BASE_W   = MEM_ADDR_WIDTH - 4;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(QWORD_COUNT - 1);

    flush_state_t                  r_state, w_next_state;
    logic [IDX_WIDTH-1:0]          r_idx, w_next_idx;
    logic [BASE_W-1:0]             r_base;
    logic [IDX_WIDTH:0]            r_wb_cnt, w_next_wb_cnt;
    logic                          r_conflict, w_next_conflict;

    logic [QWORD_COUNT-1:0]        r_flushing_n, w_flushing_n;
    logic                          r_cleaned_n, w_cleaned_n;
    logic                          r_mem_req, w_mem_req;
    logic [MEM_ADDR_WIDTH-1:0]     r_mem_addr, w_mem_addr;
    logic [QWORD_BITS-1:0]         r_mem_wdata, w_mem_wdata;
    logic                          r_busy, w_busy;
    logic                          r_done, w_done;
    logic [IDX_WIDTH:0]            r_wb_count_o, w_wb_count_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_base     <= '0;
            r_wb_cnt   <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_idx      <= w_next_idx;
            r_wb_cnt   <= w_next_wb_cnt;
            r_conflict <= w_next_conflict;
            if (r_state == ST_IDLE && flush_req_i)
                r_base <= base_addr_i[MEM_ADDR_WIDTH-1:4];
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_idx      = r_idx;
        w_next_wb_cnt   = r_wb_cnt;
        w_next_conflict = r_conflict;
        unique case (r_state)
            ST_IDLE: begin
                if (flush_req_i) begin
                    w_next_state  = ST_SCAN;
                    w_next_idx    = '0;
                    w_next_wb_cnt = '0;
                end
            end
            ST_SCAN: begin
                if (dirty_i[r_idx])
                    w_next_state = ST_READ;
                else if (r_idx == LAST_IDX)
                    w_next_state = ST_DONE;
                else
                    w_next_idx = r_idx + 1'b1;
            end
            ST_READ: begin
                w_next_state    = ST_WRITE;
                w_next_conflict = wr_conflict_i;
            end
            ST_WRITE: begin
                w_next_conflict = r_conflict | wr_conflict_i;
                if (mem_ack_i)
                    w_next_state = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (!r_conflict)
                    w_next_wb_cnt = r_wb_cnt + 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SCAN;
                    w_next_idx   = r_idx + 1'b1;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        w_busy       = (w_next_state != ST_IDLE);
        w_done       = (w_next_state == ST_DONE);
        w_mem_req    = (w_next_state == ST_WRITE);
        w_flushing_n = '1;
        w_cleaned_n  = 1'b1;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_wb_count_o = r_wb_count_o;
        if (w_next_state == ST_UPDATE) begin
            w_flushing_n = ~(QWORD_COUNT'(1) << w_next_idx);
            w_cleaned_n  = w_next_conflict;
        end
        // Read data arrives during READ for the index presented during SCAN.
        if (r_state == ST_READ) begin
            w_mem_addr  = {r_base + BASE_W'(r_idx), 4'b0000};
            w_mem_wdata = qword_data_i;
        end
        if (w_next_state == ST_DONE)
            w_wb_count_o = w_next_wb_cnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flushing_n <= '1;
            r_cleaned_n  <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wb_count_o <= '0;
        end else begin
            r_flushing_n <= w_flushing_n;
            r_cleaned_n  <= w_cleaned_n;
            r_mem_req    <= w_mem_req;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_wb_count_o <= w_wb_count_o;
        end
    end

    assign qword_addr_o = r_idx;
    assign flushing_n_o = r_flushing_n;
    assign cleaned_n_o  = r_cleaned_n;
    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign wb_count_o   = r_wb_count_o;

endmodule

// File: tb/tb_data_cache_flush_ctrl.sv
// Directed bench for data_cache_flush_ctrl: scenario tasks with hand-computed expectations.
module tb_data_cache_flush_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_req_i;
    logic [31:0]  base_addr_i;
    logic [7:0]   dirty_i;
    logic         wr_conflict_i;
    logic [2:0]   qword_addr_o;
    logic [127:0] qword_data_i;
    logic [7:0]   flushing_n_o;
    logic         cleaned_n_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic         mem_ack_i;
    logic         busy_o;
    logic         done_o;
    logic [3:0]   wb_count_o;

    int errors = 0;
    int checks = 0;

    data_cache_flush_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i), .base_addr_i(base_addr_i),
        .dirty_i(dirty_i), .wr_conflict_i(wr_conflict_i), .qword_addr_o(qword_addr_o),
        .qword_data_i(qword_data_i), .flushing_n_o(flushing_n_o), .cleaned_n_o(cleaned_n_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .busy_o(busy_o), .done_o(done_o), .wb_count_o(wb_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] pat(input logic [2:0] i);
        pat = {32'h1111_0000 | 32'(i), 32'h2222_0000 | 32'(i),
               32'h3333_0000 | 32'(i), 32'h4444_0000 | 32'(i)};
    endfunction

    // Block read port model: one cycle of latency from address to data.
    always @(posedge clk_i) qword_data_i <= pat(qword_addr_o);

    logic [31:0]  wr_addr_q[$];
    logic [127:0] wr_data_q[$];
    logic [7:0]   strb_q[$];
    logic         cln_q[$];
    int           done_cnt = 0;
    logic         ack_en = 1'b1;
    int           ack_delay = 2;
    int           req_cnt = 0;

    // Monitor plus memory responder; ack goes high on the third cycle of a request.
    always @(negedge clk_i) begin
        if (flushing_n_o !== 8'hFF) begin
            strb_q.push_back(flushing_n_o);
            cln_q.push_back(cleaned_n_o);
        end
        if (done_o === 1'b1) done_cnt++;
        if (ack_en && mem_req_o === 1'b1 && !mem_ack_i) begin
            if (req_cnt == ack_delay) begin
                mem_ack_i = 1'b1;
                wr_addr_q.push_back(mem_addr_o);
                wr_data_q.push_back(mem_wdata_o);
            end else begin
                req_cnt++;
            end
        end else begin
            mem_ack_i = 1'b0;
            req_cnt   = 0;
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        strb_q.delete();
        cln_q.delete();
    endtask

    task automatic start_flush(input logic [31:0] base);
        base_addr_i = base;
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            if (done_o === 1'b1) begin
                cyc = c;
                break;
            end
            tick();
        end
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        checks += 9;
        if (flushing_n_o !== 8'hFF) begin errors++; $display("FAIL reset_strobe: got %h want ff", flushing_n_o); end
        if (cleaned_n_o !== 1'b1) begin errors++; $display("FAIL reset_cleaned: got %b want 1", cleaned_n_o); end
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        if (wb_count_o !== 4'd0) begin errors++; $display("FAIL reset_wb: got %0d want 0", wb_count_o); end
        if (qword_addr_o !== 3'd0) begin errors++; $display("FAIL reset_qaddr: got %0d want 0", qword_addr_o); end
        if (mem_addr_o !== 32'd0) begin errors++; $display("FAIL reset_maddr: got %h want 0", mem_addr_o); end
        if (mem_wdata_o !== 128'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata_o); end
    endtask

    task automatic test_all_clean();
        int cyc;
        clear_logs();
        dirty_i = 8'h00;
        start_flush(32'h0000_0100);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL clean_busy_rise: got %b want 1", busy_o); end
        wait_done(40, cyc);
        checks += 4;
        if (cyc != 9) begin errors++; $display("FAIL clean_done_cycle: got %0d want 9", cyc); end
        if (wb_count_o !== 4'd0) begin errors++; $display("FAIL clean_wb: got %0d want 0", wb_count_o); end
        if (wr_addr_q.size() != 0) begin errors++; $display("FAIL clean_writes: got %0d want 0", wr_addr_q.size()); end
        if (strb_q.size() != 0) begin errors++; $display("FAIL clean_strobes: got %0d want 0", strb_q.size()); end
        tick();
    endtask

    task automatic test_dirty_ends();
        int cyc;
        clear_logs();
        dirty_i = 8'h81;
        start_flush(32'h1000_0040);
        wait_done(80, cyc);
        checks += 4;
        if (cyc != 19) begin errors++; $display("FAIL ends_done_cycle: got %0d want 19", cyc); end
        if (wb_count_o !== 4'd2) begin errors++; $display("FAIL ends_wb: got %0d want 2", wb_count_o); end
        if (wr_addr_q.size() != 2) begin
            errors++; $display("FAIL ends_nwrites: got %0d want 2", wr_addr_q.size());
        end else begin
            checks += 4;
            if (wr_addr_q[0] !== 32'h1000_0040) begin errors++; $display("FAIL ends_addr0: got %h want 10000040", wr_addr_q[0]); end
            if (wr_addr_q[1] !== 32'h1000_00B0) begin errors++; $display("FAIL ends_addr1: got %h want 100000b0", wr_addr_q[1]); end
            if (wr_data_q[0] !== pat(3'd0)) begin errors++; $display("FAIL ends_data0: got %h want %h", wr_data_q[0], pat(3'd0)); end
            if (wr_data_q[1] !== pat(3'd7)) begin errors++; $display("FAIL ends_data1: got %h want %h", wr_data_q[1], pat(3'd7)); end
        end
        if (strb_q.size() != 2) begin
            errors++; $display("FAIL ends_nstrobes: got %0d want 2", strb_q.size());
        end else begin
            checks += 4;
            if (strb_q[0] !== 8'hFE) begin errors++; $display("FAIL ends_strobe0: got %h want fe", strb_q[0]); end
            if (strb_q[1] !== 8'h7F) begin errors++; $display("FAIL ends_strobe1: got %h want 7f", strb_q[1]); end
            if (cln_q[0] !== 1'b0) begin errors++; $display("FAIL ends_cleaned0: got %b want 0", cln_q[0]); end
            if (cln_q[1] !== 1'b0) begin errors++; $display("FAIL ends_cleaned1: got %b want 0", cln_q[1]); end
        end
        tick();
    endtask

    task automatic test_conflict();
        int cyc;
        bit seen = 1'b0;
        clear_logs();
        dirty_i = 8'h04;
        start_flush(32'h0000_0000);
        for (int c = 0; c < 40 && !seen; c++) begin
            if (mem_req_o === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL conf_req_timeout: got 0 want 1"); end
        wr_conflict_i = 1'b1;
        tick();
        wr_conflict_i = 1'b0;
        wait_done(40, cyc);
        checks += 2;
        if (wb_count_o !== 4'd0) begin errors++; $display("FAIL conf_wb: got %0d want 0", wb_count_o); end
        if (strb_q.size() != 1) begin
            errors++; $display("FAIL conf_nstrobes: got %0d want 1", strb_q.size());
        end else begin
            checks += 2;
            if (strb_q[0] !== 8'hFB) begin errors++; $display("FAIL conf_strobe: got %h want fb", strb_q[0]); end
            if (cln_q[0] !== 1'b1) begin errors++; $display("FAIL conf_cleaned: got %b want 1", cln_q[0]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int d0;
        clear_logs();
        dirty_i = 8'h00;
        d0 = done_cnt;
        flush_req_i = 1'b1;
        tick();
        wait_done(40, cyc);
        checks += 2;
        if (cyc != 9) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 9", cyc); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_one_done: got %0d want 1", done_cnt - d0); end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b want 0", busy_o); end
        tick();
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", busy_o); end
        flush_req_i = 1'b0;
        wait_done(40, cyc);
        tick();
        tick();
        checks++;
        if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_total_done: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_late_dirty();
        int cyc;
        bit seen = 1'b0;
        clear_logs();
        dirty_i = 8'h00;
        start_flush(32'h2000_0000);
        for (int c = 0; c < 20 && !seen; c++) begin
            if (qword_addr_o === 3'd5) seen = 1'b1;
            else tick();
        end
        dirty_i = 8'h02;
        wait_done(40, cyc);
        checks += 2;
        if (wb_count_o !== 4'd0) begin errors++; $display("FAIL late_wb1: got %0d want 0", wb_count_o); end
        if (wr_addr_q.size() != 0) begin errors++; $display("FAIL late_writes1: got %0d want 0", wr_addr_q.size()); end
        tick();
        clear_logs();
        start_flush(32'h2000_0000);
        wait_done(60, cyc);
        checks += 3;
        if (wb_count_o !== 4'd1) begin errors++; $display("FAIL late_wb2: got %0d want 1", wb_count_o); end
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h2000_0010) begin
            errors++; $display("FAIL late_addr2: got n=%0d want one write at 20000010", wr_addr_q.size());
        end
        if (strb_q.size() != 1 || strb_q[0] !== 8'hFD) begin
            errors++; $display("FAIL late_strobe2: got n=%0d want one strobe fd", strb_q.size());
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        bit seen = 1'b0;
        bit reissued = 1'b0;
        clear_logs();
        ack_en = 1'b0;
        dirty_i = 8'h01;
        start_flush(32'h0000_0000);
        for (int c = 0; c < 20 && !seen; c++) begin
            if (mem_req_o === 1'b1) seen = 1'b1;
            else tick();
        end
        tick();
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_req_timeout: got 0 want 1"); end
        rst_i = 1'b1;
        #1;
        checks += 4;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", mem_req_o); end
        if (flushing_n_o !== 8'hFF) begin errors++; $display("FAIL rst_mid_strobe: got %h want ff", flushing_n_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        if (wb_count_o !== 4'd0) begin errors++; $display("FAIL rst_mid_wb: got %0d want 0", wb_count_o); end
        tick();
        rst_i = 1'b0;
        ack_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_req_o !== 1'b0) reissued = 1'b1;
        end
        checks++;
        if (reissued) begin errors++; $display("FAIL rst_no_reissue: got 1 want 0"); end
    endtask

    initial begin
        rst_i = 1'b1;
        flush_req_i = 1'b0;
        base_addr_i = '0;
        dirty_i = '0;
        wr_conflict_i = 1'b0;
        mem_ack_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        test_reset();
        test_all_clean();
        test_dirty_ends();
        test_conflict();
        test_back_to_back();
        test_late_dirty();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
